// File: rtl/keypad_pkg.sv
// keypad_pkg: FSM states, key map and column reset pattern shared by the keypad scanner files
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
  localparam logic [15:0][3:0] KEYMAP = 64'hDF0E_C987_B654_A321;
  localparam logic [3:0] COL_RESET = 4'b1110;
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    return !v[0] ? 2'd0 : !v[1] ? 2'd1 : !v[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad pins and key-code outputs; master is the scanner, slave the pin/display side
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  modport master (input row_n, output col_n, key_code, key_valid, key_held);
  modport slave (output row_n, input col_n, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: saturating count of consecutive cycles with level high; done on the target-th one
module keypad_debounce #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_level,
  input  logic         i_clear,
  input  logic [W-1:0] i_target,
  output logic         o_done
);
  logic [W-1:0] r_cnt;
  logic [W-1:0] w_inc;
  assign w_inc  = (r_cnt == i_target) ? r_cnt : r_cnt + 1'b1;
  assign o_done = i_level && !i_clear && (w_inc == i_target);
  // run count restarts whenever the level drops or the owner clears it
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear || !i_level) r_cnt <= '0;
    else r_cnt <= w_inc;
  end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scan with press/release debounce; KEYPAD_REPEAT_EN adds auto-repeat strobes
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 200000,
  parameter int REPEAT_CNT   = 5000000
) (
  input logic clk,
  input logic rst_n,
  keypad_scanner_if.master kp
);
  localparam int MAX_SD = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int MAXP   = (MAX_SD > REPEAT_CNT) ? MAX_SD : REPEAT_CNT;
  localparam int CW     = $clog2(MAXP) + 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_TARGET  = CW'(DEBOUNCE_CNT);
`ifdef KEYPAD_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST   = CW'(REPEAT_CNT - 1);
  logic [CW-1:0] r_rep;
`endif
  logic [3:0]    r_meta;
  logic [3:0]    r_rs;
  state_t        r_state;
  logic [CW-1:0] r_dwell;
  logic [3:0]    r_col_n;
  logic [1:0]    r_row;
  logic [1:0]    r_col;
  logic [3:0]    r_code;
  logic          r_valid;
  logic          r_held;
  logic          w_bit;
  logic          w_level;
  logic          w_clear;
  logic          w_done;
  logic [3:0]    w_col_next;
  assign w_bit      = r_rs[r_row];
  assign w_level    = (r_state == RELEASE) ? w_bit : !w_bit;
  assign w_clear    = (r_state == SCAN) || (r_state == PRESSED);
  assign w_col_next = {r_col_n[2:0], r_col_n[3]};
  keypad_debounce #(.W(CW)) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_level (w_level),
    .i_clear (w_clear),
    .i_target(DB_TARGET),
    .o_done  (w_done)
  );
  // two-flop synchroniser for the asynchronous row lines
  always_ff @(posedge clk) begin
    if (!rst_n) {r_meta, r_rs} <= 8'hFF;
    else {r_meta, r_rs} <= {kp.row_n, r_meta};
  end
  // scan / debounce / hold / release state machine with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= SCAN;
      r_dwell <= '0;
      r_col_n <= COL_RESET;
      r_row   <= '0;
      r_col   <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep   <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_dwell <= '0;
`ifdef KEYPAD_REPEAT_EN
      r_rep   <= '0;
`endif
      unique case (r_state)
        SCAN: begin
          if (r_dwell != DWELL_LAST) r_dwell <= r_dwell + 1'b1;
          else if (r_rs != 4'hF) begin
            r_row   <= low_idx(r_rs);
            r_col   <= low_idx(r_col_n);
            r_state <= DEBOUNCE;
          end else r_col_n <= w_col_next;
        end
        DEBOUNCE: begin
          if (w_bit) begin
            r_state <= SCAN;
            r_col_n <= w_col_next;
          end else if (w_done) begin
            r_state <= PRESSED;
            r_code  <= KEYMAP[{r_row, r_col}];
            r_valid <= 1'b1;
            r_held  <= 1'b1;
          end
        end
        PRESSED: begin
          if (w_bit) r_state <= RELEASE;
`ifdef KEYPAD_REPEAT_EN
          else begin
            r_rep   <= (r_rep == REP_LAST) ? '0 : r_rep + 1'b1;
            r_valid <= (r_rep == REP_LAST);
          end
`endif
        end
        RELEASE: begin
          if (!w_bit) r_state <= PRESSED;
          else if (w_done) begin
            r_held  <= 1'b0;
            r_state <= SCAN;
            r_col_n <= w_col_next;
          end
        end
      endcase
    end
  end
  assign kp.col_n     = r_col_n;
  assign kp.key_code  = r_code;
  assign kp.key_valid = r_valid;
  assign kp.key_held  = r_held;
endmodule
